// File: rtl/histogram_controller.sv
// Double-banked 256-bin intensity histogram: one bank accumulates the current frame while
// the other is held for display. The roles swap at frame end and the new bank is cleared.
module histogram_controller (
  input  logic        iClk,
  input  logic        iRST_N,
  input  logic        iFrameStart,
  input  logic        iFrameEnd,
  input  logic        iValid,
  input  logic [7:0]  iPixel,
  input  logic [7:0]  iDispAddr,
  output logic [8:0]  oDispRdAddr,
  output logic [8:0]  oAccRdAddr,
  input  logic [19:0] iAccRdData,
  output logic        oWrEn,
  output logic [8:0]  oWrAddr,
  output logic [19:0] oWrData,
  output logic        oBank,
  output logic [19:0] oPeak,
  output logic [7:0]  oPeakBin,
  output logic        oFrameReady,
  output logic        oDropped
);

  typedef enum logic [2:0] {StClear, StWait, StAccum, StFlush, StSwap} stateE;

  stateE       state;
  logic [7:0]  clearCnt;
  logic        rdValid;
  logic [8:0]  rdAddr;
  logic        wr2En;
  logic [8:0]  wr2Addr;
  logic [19:0] wr2Data;
  logic [19:0] runMax;
  logic [7:0]  runBin;
  logic [19:0] fwdData;
  logic [19:0] incData;

  assign oDispRdAddr = {~oBank, iDispAddr};
  assign oAccRdAddr  = {oBank, iPixel};

  // The RAM returns old data on read-during-write, so the two writes still in flight
  // (on the port now, and committed on the edge that captured the read) are forwarded.
  // The newer write takes priority.
  always_comb begin
    fwdData = iAccRdData;
    if (wr2En && (wr2Addr == rdAddr)) fwdData = wr2Data;
    if (oWrEn && (oWrAddr == rdAddr)) fwdData = oWrData;
    incData = (fwdData == 20'hFFFFF) ? fwdData : fwdData + 20'd1;
  end

  always_ff @(posedge iClk or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= StClear;
      clearCnt    <= 8'd0;
      rdValid     <= 1'b0;
      rdAddr      <= 9'd0;
      wr2En       <= 1'b0;
      wr2Addr     <= 9'd0;
      wr2Data     <= 20'd0;
      runMax      <= 20'd0;
      runBin      <= 8'd0;
      oWrEn       <= 1'b0;
      oWrAddr     <= 9'd0;
      oWrData     <= 20'd0;
      oBank       <= 1'b0;
      oPeak       <= 20'd0;
      oPeakBin    <= 8'd0;
      oFrameReady <= 1'b0;
      oDropped    <= 1'b0;
    end else begin
      oFrameReady <= 1'b0;
      oDropped    <= 1'b0;
      oWrEn       <= 1'b0;
      wr2En       <= oWrEn;
      wr2Addr     <= oWrAddr;
      wr2Data     <= oWrData;
      rdValid     <= (state == StAccum) && iValid;
      rdAddr      <= {oBank, iPixel};

      if (rdValid) begin
        oWrEn   <= 1'b1;
        oWrAddr <= rdAddr;
        oWrData <= incData;
        // Strictly greater: an earlier bin that reached the same count keeps the peak.
        if (incData > runMax) begin
          runMax <= incData;
          runBin <= rdAddr[7:0];
        end
      end

      case (state)
        StClear: begin
          oWrEn    <= 1'b1;
          oWrAddr  <= {oBank, clearCnt};
          oWrData  <= 20'd0;
          clearCnt <= clearCnt + 8'd1;
          if (clearCnt == 8'hFF) state <= StWait;
          if (iFrameStart) oDropped <= 1'b1;
        end
        StWait: begin
          if (iFrameStart) begin
            state  <= StAccum;
            runMax <= 20'd0;
            runBin <= 8'd0;
          end
        end
        StAccum: begin
          if (iFrameEnd) state <= StFlush;
        end
        StFlush: begin
          // Once nothing is left to compute, the last write is on the port this cycle.
          if (!rdValid) begin
            state       <= StSwap;
            oBank       <= ~oBank;
            oPeak       <= runMax;
            oPeakBin    <= runBin;
            oFrameReady <= 1'b1;
          end
        end
        StSwap: begin
          state <= StClear;
        end
        default: begin
          state <= StClear;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_controller.sv
// Randomized bench for histogram_controller with a behavioural RAM and per-frame bin model.
module tb_histogram_controller;

  logic        iClk = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iFrameStart = 1'b0;
  logic        iFrameEnd = 1'b0;
  logic        iValid = 1'b0;
  logic [7:0]  iPixel = 8'd0;
  logic [7:0]  iDispAddr = 8'd0;
  logic [8:0]  oDispRdAddr;
  logic [8:0]  oAccRdAddr;
  logic [19:0] iAccRdData;
  logic        oWrEn;
  logic [8:0]  oWrAddr;
  logic [19:0] oWrData;
  logic        oBank;
  logic [19:0] oPeak;
  logic [7:0]  oPeakBin;
  logic        oFrameReady;
  logic        oDropped;

  histogram_controller dut (
    .iClk        (iClk),
    .iRST_N      (iRST_N),
    .iFrameStart (iFrameStart),
    .iFrameEnd   (iFrameEnd),
    .iValid      (iValid),
    .iPixel      (iPixel),
    .iDispAddr   (iDispAddr),
    .oDispRdAddr (oDispRdAddr),
    .oAccRdAddr  (oAccRdAddr),
    .iAccRdData  (iAccRdData),
    .oWrEn       (oWrEn),
    .oWrAddr     (oWrAddr),
    .oWrData     (oWrData),
    .oBank       (oBank),
    .oPeak       (oPeak),
    .oPeakBin    (oPeakBin),
    .oFrameReady (oFrameReady),
    .oDropped    (oDropped)
  );

  always #5 iClk = ~iClk;

  // Synchronous RAM, read-during-write returns old contents.
  logic [19:0] mem [512];
  logic        preloadEn = 1'b0;
  logic [8:0]  preloadAddr = 9'd0;
  logic [19:0] preloadData = 20'd0;

  always @(posedge iClk) begin
    if (oWrEn) mem[oWrAddr] <= oWrData;
    if (preloadEn) mem[preloadAddr] <= preloadData;
    iAccRdData <= mem[oAccRdAddr];
  end

  int badWr = 0;
  int readyCnt = 0;
  always @(posedge iClk) begin
    if (iRST_N && oWrEn && (oWrAddr[8] != oBank)) badWr++;
    if (iRST_N && oFrameReady) readyCnt++;
  end

  int   vecCnt = 0;
  int   errCnt = 0;
  int   expCnt [256];
  int   expPeak;
  int   expPeakBin;
  logic expBank = 1'b0;
  int   framesDone = 0;
  int   pixQ [$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic modelPixel(input int b);
    if (expCnt[b] < 'hFFFFF) expCnt[b]++;
    if (expCnt[b] > expPeak) begin
      expPeak    = expCnt[b];
      expPeakBin = b;
    end
  endtask

  task automatic doReset();
    int idx;
    int badClear;
    iRST_N      = 1'b0;
    iFrameStart = 1'b0;
    iFrameEnd   = 1'b0;
    iValid      = 1'b0;
    repeat (3) tick();
    checkVal("rst_bank", oBank, 0);
    checkVal("rst_wren", oWrEn, 0);
    checkVal("rst_ready", oFrameReady, 0);
    checkVal("rst_dropped", oDropped, 0);
    checkVal("rst_peak", oPeak, 0);
    checkVal("rst_peakbin", oPeakBin, 0);
    expBank = 1'b0;
    iRST_N  = 1'b1;
    idx      = 0;
    badClear = 0;
    for (int c = 0; c < 262; c++) begin
      tick();
      if (oWrEn) begin
        if ((oWrAddr != idx[8:0]) || (oWrData != 20'd0)) badClear++;
        idx++;
      end
    end
    checkVal("clear_count", idx, 256);
    checkVal("clear_seq", badClear, 0);
    checkVal("bank_after_clear", oBank, 0);
  endtask

  // Accumulates pixQ as one frame; optional preload of one bin and a rejected start afterwards.
  task automatic runFrame(input bit gaps, input int preBin, input int preVal, input bit dropTest);
    int   n;
    int   b;
    bit   got;
    logic oldBank;
    logic [8:0] a;
    for (int i = 0; i < 256; i++) expCnt[i] = 0;
    expPeak    = 0;
    expPeakBin = 0;
    if (preBin >= 0) begin
      preloadEn   = 1'b1;
      preloadAddr = {expBank, preBin[7:0]};
      preloadData = preVal[19:0];
      tick();
      preloadEn   = 1'b0;
      expCnt[preBin] = preVal;
    end
    iFrameStart = 1'b1;
    tick();
    iFrameStart = 1'b0;
    n = pixQ.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        repeat ($urandom_range(1, 2)) tick();
      end
      b = pixQ[i];
      iDispAddr = 8'($urandom);
      #1;
      if (i < 3) checkVal("disp_addr", oDispRdAddr, {~expBank, iDispAddr});
      iValid    = 1'b1;
      iPixel    = b[7:0];
      iFrameEnd = (i == n - 1);
      modelPixel(b);
      tick();
      iValid    = 1'b0;
      iFrameEnd = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (oFrameReady) got = 1'b1;
      else tick();
    end
    checkVal("frame_ready", got, 1);
    oldBank = expBank;
    expBank = ~expBank;
    framesDone++;
    checkVal("bank_swap", oBank, expBank);
    checkVal("peak", oPeak, expPeak);
    checkVal("peak_bin", oPeakBin, expPeakBin);
    tick();
    checkVal("ready_one_shot", oFrameReady, 0);
    for (int i = 0; i < 256; i++) begin
      a = {oldBank, 8'(i)};
      checkVal($sformatf("bin%0d", i), mem[a], expCnt[i]);
    end
    if (dropTest) begin
      repeat (9) tick();
      iFrameStart = 1'b1;
      tick();
      iFrameStart = 1'b0;
      checkVal("dropped", oDropped, 1);
      for (int i = 0; i < 5; i++) begin
        iValid = 1'b1;
        iPixel = 8'($urandom);
        tick();
        if (i == 0) checkVal("dropped_one_shot", oDropped, 0);
      end
      iValid = 1'b0;
    end
    repeat (262) tick();
    pixQ.delete();
  endtask

  initial begin
    doReset();

    for (int i = 0; i < 10; i++) pixQ.push_back(7);
    runFrame(1'b0, -1, 0, 1'b1);

    pixQ = '{5, 5, 9, 5, 9, 9, 5};
    runFrame(1'b0, -1, 0, 1'b0);

    pixQ = '{200, 200, 200};
    runFrame(1'b0, 200, 'hFFFFE, 1'b0);

    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(20, 200);
      for (int i = 0; i < n; i++) begin
        if (f[0]) pixQ.push_back($urandom_range(0, 3));
        else pixQ.push_back($urandom_range(0, 255));
      end
      runFrame(f[1], -1, 0, 1'b0);
    end

    // Reset in the middle of accumulation, then a clean frame.
    iFrameStart = 1'b1;
    tick();
    iFrameStart = 1'b0;
    for (int i = 0; i < 20; i++) begin
      iValid = 1'b1;
      iPixel = 8'($urandom_range(0, 3));
      tick();
    end
    iValid = 1'b0;
    doReset();
    for (int i = 0; i < 100; i++) pixQ.push_back($urandom_range(0, 7));
    runFrame(1'b1, -1, 0, 1'b0);

    checkVal("no_display_writes", badWr, 0);
    checkVal("ready_pulses", readyCnt, framesDone);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
